// File: rtl/regfile_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_arbiter
// Description : Shares a single-port register file between two requesters
//               (0 = system controller RX command path, 1 = configuration /
//               test master). Round-robin arbitration in IDLE, then
//               sequences one write or one read against the register file.
//               Read data and completion go back to the owning requester.
//               A read that does not complete within RD_TIMEOUT cycles ends
//               with an error completion.
// Ports       : CLK, rst_n (async, active low)
//               Rn_Req/Wr/Address/WrData   request from requester n
//               Rn_Gnt                     combinational accept
//               Rn_RdData/RdValid/RdErr    read completion to requester n
//               WrEn/RdEn/Address/WrData   register file command side
//               Rd_data/Rd_data_valid      register file read return
//               Busy                       high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int RD_TIMEOUT   = 15,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic                    R0_Req,
    input  logic                    R0_Wr,
    input  logic [ADDRESS_SIZE-1:0] R0_Address,
    input  logic [DATA_WIDTH-1:0]   R0_WrData,
    output logic                    R0_Gnt,
    output logic [DATA_WIDTH-1:0]   R0_RdData,
    output logic                    R0_RdValid,
    output logic                    R0_RdErr,
    input  logic                    R1_Req,
    input  logic                    R1_Wr,
    input  logic [ADDRESS_SIZE-1:0] R1_Address,
    input  logic [DATA_WIDTH-1:0]   R1_WrData,
    output logic                    R1_Gnt,
    output logic [DATA_WIDTH-1:0]   R1_RdData,
    output logic                    R1_RdValid,
    output logic                    R1_RdErr,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [ADDRESS_SIZE-1:0] Address,
    output logic [DATA_WIDTH-1:0]   WrData,
    input  logic [DATA_WIDTH-1:0]   Rd_data,
    input  logic                    Rd_data_valid,
    output logic                    Busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ      = 2'd2,
        READ_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(RD_TIMEOUT - 1);

    state_t                  state;
    state_t                  state_next;
    logic                    owner;
    logic                    last_owner;
    logic                    winner;
    logic                    accept;
    logic                    sel_wr;
    logic [ADDRESS_SIZE-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    timeout;

    // With both requesting, the one that did not own the last transfer wins;
    // otherwise the single active requester wins (0 if R0 requests).
    assign winner    = (R0_Req && R1_Req) ? ~last_owner : ~R0_Req;
    assign R0_Gnt    = (state == IDLE) && R0_Req && !winner;
    assign R1_Gnt    = (state == IDLE) && R1_Req &&  winner;
    assign accept    = R0_Gnt || R1_Gnt;

    assign sel_wr    = winner ? R1_Wr     : R0_Wr;
    assign sel_addr  = winner ? R1_Address : R0_Address;
    assign sel_wdata = winner ? R1_WrData : R0_WrData;

    assign timeout   = (cnt == TIMEOUT_LAST);

    assign WrEn      = (state == WRITE);
    assign RdEn      = (state == READ);
    assign Busy      = (state != IDLE);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = sel_wr ? WRITE : READ;
                end
            end
            WRITE:     state_next = IDLE;
            READ:      state_next = READ_WAIT;
            READ_WAIT: begin
                if (Rd_data_valid || timeout) begin
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: captured request, timeout counter and read completions
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            Address    <= '0;
            WrData     <= '0;
            cnt        <= '0;
            R0_RdData  <= '0;
            R1_RdData  <= '0;
            R0_RdValid <= 1'b0;
            R1_RdValid <= 1'b0;
            R0_RdErr   <= 1'b0;
            R1_RdErr   <= 1'b0;
        end else begin
            R0_RdValid <= 1'b0;
            R1_RdValid <= 1'b0;
            R0_RdErr   <= 1'b0;
            R1_RdErr   <= 1'b0;

            if (accept) begin
                owner      <= winner;
                last_owner <= winner;
                Address    <= sel_addr;
                if (sel_wr) begin
                    WrData <= sel_wdata;
                end
            end

            if (state == READ) begin
                cnt <= '0;
            end else if ((state == READ_WAIT) && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end

            // Returned data takes priority over a timeout in the same cycle.
            if (state == READ_WAIT) begin
                if (Rd_data_valid) begin
                    if (owner) begin
                        R1_RdData  <= Rd_data;
                        R1_RdValid <= 1'b1;
                    end else begin
                        R0_RdData  <= Rd_data;
                        R0_RdValid <= 1'b1;
                    end
                end else if (timeout) begin
                    if (owner) begin
                        R1_RdData  <= '0;
                        R1_RdValid <= 1'b1;
                        R1_RdErr   <= 1'b1;
                    end else begin
                        R0_RdData  <= '0;
                        R0_RdValid <= 1'b1;
                        R0_RdErr   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
